// File: rtl/axis_stim_sequencer.sv
// axis_stim_sequencer
//   Stimulus source for encap/decap datapath harnesses. After reset it holds
//   dut_reset high for RESET_CYCLES edges and then waits SETTLE_CYCLES edges.
//   It then emits deterministic AXI-Stream packets round-robin across NUM_CH
//   source ports, with NetFPGA-style tuser metadata. It counts the completed
//   packets and raises done once NUM_CH*NUM_PKTS packets have been sent
//   (NUM_PKTS = 0 runs forever).
//
// Ports
//   fpga_sysclk    in   clock, rising edge
//   reset          in   synchronous, active-high; restarts the whole sequence
//   enable         in   permits starting new packets
//   dut_reset      out  active-high reset for the DUT
//   m_axis_*       out  AXI-Stream master (tready is an input)
//   pkt_count      out  packets fully handshaken since reset (wraps)
//   done           out  all packets sent; held until reset
//
// state    | meaning
// ---------+-----------------------------------------------
// RST_HOLD | dut_reset asserted, counting RESET_CYCLES
// SETTLE   | dut_reset released, counting SETTLE_CYCLES
// IDLE     | waiting for enable to start a packet
// SEND     | presenting beats of the current packet
// GAP      | inter-packet gap after tlast, IPG_CYCLES idle cycles
// DONE     | all packets sent, outputs quiet until reset
module axis_stim_sequencer #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int NUM_CH        = 4,
  parameter int PKT_BYTES     = 64,
  parameter int NUM_PKTS      = 16,
  parameter int RESET_CYCLES  = 200,
  parameter int SETTLE_CYCLES = 16,
  parameter int IPG_CYCLES    = 0
) (
  input  logic                      fpga_sysclk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      dut_reset,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [127:0]              m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [31:0]               pkt_count,
  output logic                      done
);

  localparam int          BPB       = C_DATA_WIDTH / 8;
  localparam int          BEATS     = (PKT_BYTES + BPB - 1) / BPB;
  localparam logic [15:0] LAST_BEAT = 16'(BEATS - 1);
  localparam logic [1:0]  CH_LAST   = 2'(NUM_CH - 1);
  localparam logic [31:0] TOTAL     = 32'(NUM_CH * NUM_PKTS);

  typedef enum logic [2:0] {RST_HOLD, SETTLE, IDLE, SEND, GAP, DONE} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [15:0]               beat_q, beat_d;
  logic [7:0]                seq_q, seq_d;
  logic [1:0]                ch_q, ch_d;
  logic [31:0]               pkt_count_q, pkt_count_d;
  logic                      done_q, done_d;
  logic                      dut_reset_q, dut_reset_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic [C_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [BPB-1:0]            tkeep_q, tkeep_d;
  logic [127:0]              tuser_q, tuser_d;

  logic                      load;
  logic [15:0]               load_beat;
  logic [7:0]                load_seq;
  logic [1:0]                load_ch;

  // Byte k of the packet is seq + k; bytes past the end of the packet are 0.
  function automatic logic [C_DATA_WIDTH-1:0] beat_data(input logic [7:0] s,
                                                        input logic [15:0] b);
    logic [C_DATA_WIDTH-1:0] d;
    int base;
    d    = '0;
    base = int'(b) * BPB;
    for (int i = 0; i < BPB; i++)
      if (base + i < PKT_BYTES) d[i*8 +: 8] = s + 8'(base + i);
    return d;
  endfunction

  function automatic logic [BPB-1:0] beat_keep(input logic [15:0] b);
    logic [BPB-1:0] k;
    int base;
    k    = '0;
    base = int'(b) * BPB;
    for (int i = 0; i < BPB; i++) k[i] = (base + i < PKT_BYTES);
    return k;
  endfunction

  function automatic logic [127:0] beat_user(input logic [1:0] c);
    logic [127:0] u;
    u          = '0;
    u[15:0]    = 16'(PKT_BYTES);
    u[23:16]   = 8'd1 << {c, 1'b0};
    return u;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    ch_d        = ch_q;
    pkt_count_d = pkt_count_q;
    done_d      = done_q;
    dut_reset_d = dut_reset_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tuser_d     = tuser_q;
    load        = 1'b0;
    load_beat   = '0;
    load_seq    = seq_q;
    load_ch     = ch_q;

    case (state_q)
      RST_HOLD: begin
        if (cnt_q == '0) begin
          dut_reset_d = 1'b0;
          if (SETTLE_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = SETTLE;
            cnt_d   = 32'(SETTLE_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 32'd1;
      end
      IDLE: begin
        if (enable) load = 1'b1;
      end
      SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (!tlast_q) begin
            load      = 1'b1;
            load_beat = beat_q + 16'd1;
          end else begin
            pkt_count_d = pkt_count_q + 32'd1;
            seq_d       = seq_q + 8'd1;
            ch_d        = (ch_q == CH_LAST) ? 2'd0 : ch_q + 2'd1;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            if (NUM_PKTS != 0 && pkt_count_d == TOTAL) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (IPG_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = 32'(IPG_CYCLES - 1);
            end else if (enable) begin
              // back-to-back: next packet uses the already-advanced seq/ch
              load     = 1'b1;
              load_seq = seq_d;
              load_ch  = ch_d;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        // the final gap cycle may launch the next packet directly, so the
        // idle time on the bus is exactly IPG_CYCLES
        if (cnt_q == '0) begin
          if (enable) load    = 1'b1;
          else        state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      DONE: ;
      default: state_d = RST_HOLD;
    endcase

    if (load) begin
      state_d  = SEND;
      beat_d   = load_beat;
      tvalid_d = 1'b1;
      tlast_d  = (load_beat == LAST_BEAT);
      tdata_d  = beat_data(load_seq, load_beat);
      tkeep_d  = beat_keep(load_beat);
      tuser_d  = beat_user(load_ch);
    end
  end

  always_ff @(posedge fpga_sysclk) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      cnt_q       <= 32'(RESET_CYCLES - 1);
      beat_q      <= '0;
      seq_q       <= '0;
      ch_q        <= '0;
      pkt_count_q <= '0;
      done_q      <= 1'b0;
      dut_reset_q <= 1'b1;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      ch_q        <= ch_d;
      pkt_count_q <= pkt_count_d;
      done_q      <= done_d;
      dut_reset_q <= dut_reset_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tuser_q     <= tuser_d;
    end
  end

  assign dut_reset     = dut_reset_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_count     = pkt_count_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_stim_sequencer.sv
// Bench for axis_stim_sequencer: instance 0 uses the default parameters,
// instance 1 uses 3 channels, 65-byte packets, 2 packets per channel,
// a short reset, no settle time and a 3-cycle inter-packet gap.
module tb_axis_stim_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         enable    [2];
  logic         tready    [2];
  logic         dut_reset [2];
  logic [255:0] tdata     [2];
  logic [31:0]  tkeep     [2];
  logic [127:0] tuser     [2];
  logic         tvalid    [2];
  logic         tlast     [2];
  logic [31:0]  pkt_count [2];
  logic         done      [2];

  int checks = 0;
  int errors = 0;

  localparam int R_C [2] = '{200, 5};
  localparam int S_C [2] = '{16, 0};
  localparam int I_C [2] = '{0, 3};
  localparam int PB  [2] = '{64, 65};
  localparam int NC  [2] = '{4, 3};
  localparam int NP  [2] = '{16, 2};

  axis_stim_sequencer u_a (
    .fpga_sysclk(clk), .reset(reset), .enable(enable[0]),
    .dut_reset(dut_reset[0]), .m_axis_tdata(tdata[0]), .m_axis_tkeep(tkeep[0]),
    .m_axis_tuser(tuser[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
    .m_axis_tlast(tlast[0]), .pkt_count(pkt_count[0]), .done(done[0])
  );

  axis_stim_sequencer #(
    .NUM_CH(3), .PKT_BYTES(65), .NUM_PKTS(2), .RESET_CYCLES(5),
    .SETTLE_CYCLES(0), .IPG_CYCLES(3)
  ) u_b (
    .fpga_sysclk(clk), .reset(reset), .enable(enable[1]),
    .dut_reset(dut_reset[1]), .m_axis_tdata(tdata[1]), .m_axis_tkeep(tkeep[1]),
    .m_axis_tuser(tuser[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
    .m_axis_tlast(tlast[1]), .pkt_count(pkt_count[1]), .done(done[1])
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Packet p since reset has seq = p and channel p mod nch.
  function automatic logic [255:0] m_data(int p, int b, int nbytes);
    logic [255:0] d = '0;
    for (int i = 0; i < 32; i++)
      if (b * 32 + i < nbytes) d[i*8 +: 8] = 8'((p + b * 32 + i) % 256);
    return d;
  endfunction

  function automatic logic [31:0] m_keep(int b, int nbytes);
    logic [31:0] k = '0;
    for (int i = 0; i < 32; i++) k[i] = (b * 32 + i < nbytes);
    return k;
  endfunction

  function automatic logic [127:0] m_user(int p, int nbytes, int nch);
    logic [127:0] r = 128'(nbytes);
    r[16 + 2 * (p % nch)] = 1'b1;
    return r;
  endfunction

  // ---------------- model + per-cycle compare ----------------
  bit rst_pend = 1'b0;
  bit armed    = 1'b0;
  int edges [2], pkts [2], beat [2], gap_cnt [2];
  bit in_gap [2], gap_ok [2], first_seen [2], en_always [2];
  bit prev_valid [2], prev_en [2], prev_hs_last [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_pend) begin
        armed = 1'b1;
        edges[u] = 0; pkts[u] = 0; beat[u] = 0; in_gap[u] = 0;
        first_seen[u] = 0; en_always[u] = 1; prev_hs_last[u] = 0;
        chk($sformatf("u%0d_rst_dut_reset", u), dut_reset[u], 1);
        chk($sformatf("u%0d_rst_tvalid", u), tvalid[u], 0);
        chk($sformatf("u%0d_rst_tlast", u), tlast[u], 0);
        chk($sformatf("u%0d_rst_tdata", u), tdata[u], 0);
        chk($sformatf("u%0d_rst_tkeep", u), tkeep[u], 0);
        chk($sformatf("u%0d_rst_tuser", u), tuser[u], 0);
        chk($sformatf("u%0d_rst_pkt_count", u), pkt_count[u], 0);
        chk($sformatf("u%0d_rst_done", u), done[u], 0);
      end else if (armed) begin
        int nbeats;
        bit exp_done;
        nbeats = (PB[u] + 31) / 32;
        edges[u]++;
        exp_done = (NP[u] != 0) && (pkts[u] == NC[u] * NP[u]);
        chk($sformatf("u%0d_dut_reset", u), dut_reset[u], edges[u] < R_C[u]);
        chk($sformatf("u%0d_pkt_count", u), pkt_count[u], 32'(pkts[u]));
        chk($sformatf("u%0d_done", u), done[u], exp_done);
        if (exp_done || edges[u] < R_C[u] + S_C[u] + 1)
          chk($sformatf("u%0d_idle_valid", u), tvalid[u], 0);
        if (prev_valid[u] && !prev_hs_last[u])
          chk($sformatf("u%0d_valid_hold", u), tvalid[u], 1);
        if (tvalid[u]) begin
          chk($sformatf("u%0d_tdata", u), tdata[u], m_data(pkts[u], beat[u], PB[u]));
          chk($sformatf("u%0d_tkeep", u), tkeep[u], m_keep(beat[u], PB[u]));
          chk($sformatf("u%0d_tuser", u), tuser[u], m_user(pkts[u], PB[u], NC[u]));
          chk($sformatf("u%0d_tlast", u), tlast[u], beat[u] == nbeats - 1);
          if (!prev_valid[u]) begin
            chk($sformatf("u%0d_start_enable", u), prev_en[u], 1);
            if (!first_seen[u]) begin
              first_seen[u] = 1;
              if (en_always[u])
                chk($sformatf("u%0d_first_valid_edge", u), edges[u], R_C[u] + S_C[u] + 1);
            end
          end
        end
        if (in_gap[u]) begin
          if (tvalid[u]) begin
            in_gap[u] = 0;
            if (gap_ok[u]) chk($sformatf("u%0d_gap_len", u), gap_cnt[u], I_C[u]);
          end else begin
            gap_cnt[u]++;
            gap_ok[u] &= enable[u];
          end
        end
        prev_hs_last[u] = 0;
        if (tvalid[u] && tready[u] && !reset) begin
          if (beat[u] == nbeats - 1) begin
            pkts[u]++; beat[u] = 0;
            in_gap[u] = 1; gap_cnt[u] = 0; gap_ok[u] = enable[u];
            prev_hs_last[u] = 1;
          end else begin
            beat[u]++;
          end
        end
        en_always[u] &= enable[u];
      end
      prev_valid[u] = tvalid[u];
      prev_en[u]    = enable[u];
    end
    rst_pend = reset;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] oh [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
  int n;
  bit flag;

  initial begin
    reset = 1'b1;
    enable[0] = 1'b1; enable[1] = 1'b1;
    tready[0] = 1'b1; tready[1] = 1'b1;
    repeat (10) tick();
    reset = 1'b0;

    // run until the last beat of packet 5 on instance 0, then reset there
    flag = 0;
    for (int i = 0; i < 2000 && !flag; i++) begin
      tick();
      if (pkt_count[0] == 5 && tvalid[0] && tlast[0]) flag = 1;
    end
    chk("reach_pkt5_beat1", flag, 1);
    reset = 1'b1;
    tick();
    chk("midrst_tvalid", tvalid[0], 0);
    chk("midrst_pkt_count", pkt_count[0], 0);
    chk("midrst_dut_reset", dut_reset[0], 1);
    tick();
    reset = 1'b0;

    // reset timing
    n = 0;
    do begin tick(); n++; end while (dut_reset[0] && n < 1000);
    chk("dut_reset_hold_edges", n, 200);
    n = 0;
    do begin tick(); n++; end while (!tvalid[0] && n < 1000);
    chk("settle_to_valid_edges", n, 17);

    // packet format, seq restarts at 0 after the mid-packet reset
    chk("pkt0_beat0_tdata", tdata[0],
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    chk("pkt0_tkeep", tkeep[0], 32'hffff_ffff);
    chk("pkt0_tuser", tuser[0], 128'h0001_0040);
    chk("pkt0_beat0_tlast", tlast[0], 0);
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("pkt%0d_src_onehot", p), tuser[0][23:16], oh[p]);
      chk($sformatf("pkt%0d_byte0", p), tdata[0][7:0], 8'(p));
      tick();
      if (p == 0) begin
        chk("pkt0_beat1_byte0", tdata[0][7:0], 8'h20);
        chk("pkt0_beat1_tlast", tlast[0], 1);
      end
      tick();
    end

    // random backpressure to completion
    for (int i = 0; i < 4000 && !done[0]; i++) begin
      tready[0] = 1'($urandom_range(0, 1));
      tick();
    end
    tready[0] = 1'b1;
    chk("bp_done", done[0], 1);
    chk("bp_pkt_count", pkt_count[0], 64);
    repeat (3) tick();
    chk("done_hold_tvalid", tvalid[0], 0);
    chk("done_hold", done[0], 1);

    // instance 1: partial last beat, IPG, enable drop
    enable[0] = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!tvalid[1] && n < 100);
    chk("b_first_valid_edges", n, 6);
    chk("b_pkt0_tuser", tuser[1], 128'h0001_0041);
    chk("b_pkt0_byte0", tdata[1][7:0], 8'h00);
    tick();
    chk("b_pkt0_beat1_byte0", tdata[1][7:0], 8'h20);
    tick();
    chk("b_pkt0_last_tkeep", tkeep[1], 32'h1);
    chk("b_pkt0_last_tdata", tdata[1], 256'h40);
    chk("b_pkt0_last_tlast", tlast[1], 1);
    n = 0;
    do begin tick(); n++; end while (!tvalid[1] && n < 50);
    chk("b_ipg_idle_cycles", n - 1, 3);
    chk("b_pkt1_onehot", tuser[1][23:16], 8'h04);
    chk("b_pkt1_byte0", tdata[1][7:0], 8'h01);
    enable[1] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (tvalid[1] && n < 50);
    chk("b_en_drop_beats", n, 3);
    chk("b_en_drop_pkt_count", pkt_count[1], 2);
    flag = 0;
    repeat (10) begin tick(); if (tvalid[1]) flag = 1; end
    chk("b_en_low_no_valid", flag, 0);
    enable[1] = 1'b1;
    for (int i = 0; i < 300 && !done[1]; i++) tick();
    chk("b_done", done[1], 1);
    chk("b_pkt_count", pkt_count[1], 6);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_stim_sequencer.md
Name: axis_stim_sequencer

Overview:
- Parametrised, synthesizable stimulus source for simulation harnesses of the encap/decap datapath.
- Owns the DUT reset sequence: holds an active-high DUT reset for a programmable hold time, then waits a settle period.
- Then emits deterministic AXI-Stream packets, round-robin across NUM_CH source ports, with NetFPGA-style tuser metadata.
- Counts packets and flags completion, so benches need no hand-written clock/reset/packet initial blocks.

Parameters:
C_DATA_WIDTH, 256, tdata width in bits; multiple of 8, 64..512
NUM_CH, 4, number of source ports cycled round-robin; 1..4
PKT_BYTES, 64, bytes per packet; 1..1518
NUM_PKTS, 16, packets per channel; 0 = continuous
RESET_CYCLES, 200, dut_reset hold cycles after reset deasserts; >=1
SETTLE_CYCLES, 16, idle cycles between dut_reset release and first packet; >=0
IPG_CYCLES, 0, idle cycles inserted after each tlast handshake; >=0

Ports:
fpga_sysclk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  permits starting new packets
dut_reset  out  1  active-high reset to DUT
m_axis_tdata  out  C_DATA_WIDTH  packet data, byte 0 in [7:0]
m_axis_tkeep  out  C_DATA_WIDTH/8  byte enables
m_axis_tuser  out  128  [15:0] length = PKT_BYTES; [23:16] src port one-hot = 1<<(2*ch); all other bits 0
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of packet
pkt_count  out  32  packets fully handshaken since reset; wraps at 2^32
done  out  1  high when all NUM_CH*NUM_PKTS packets have been sent

Behaviour:
- Reset (sampled on clock edge): dut_reset=1; tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0; pkt_count=0; done=0; ch=0; seq=0; state=RST_HOLD; counters cleared. Reset mid-operation aborts any packet immediately (tvalid drops on the next edge) and restarts the full sequence.
- States: RST_HOLD -> SETTLE -> IDLE -> SEND -> (GAP) -> IDLE ... -> DONE.
- RST_HOLD: dut_reset=1 for exactly RESET_CYCLES edges after reset deasserts, then dut_reset=0 and go to SETTLE.
- SETTLE: wait SETTLE_CYCLES edges, then go to IDLE. If SETTLE_CYCLES=0, go directly to IDLE.
- IDLE: if enable=1, enter SEND with tvalid=1 on the next edge; otherwise hold.
- SEND:
  - BEATS = ceil(PKT_BYTES/(C_DATA_WIDTH/8)).
  - Byte k of the packet (k = 0..PKT_BYTES-1) = (seq[7:0] + k) mod 256.
  - tkeep = all ones except on the last beat, which has the low (PKT_BYTES mod bytes-per-beat) bits set, or all ones if the remainder is 0; unused bytes are 0.
  - tuser is constant for the whole packet.
- Handshake: a beat transfers when tvalid & tready. While stalled, tdata, tkeep, tuser and tlast are held stable and tvalid stays 1. tvalid never drops mid-packet.
- On tlast handshake:
  - pkt_count++; seq++; ch = (ch+1) mod NUM_CH.
  - If NUM_PKTS != 0 and pkt_count reaches NUM_CH*NUM_PKTS: go to DONE, done=1, tvalid=0.
  - Else if IPG_CYCLES > 0: go to GAP for IPG_CYCLES edges, then IDLE.
  - Else if enable=1: next packet's first beat is presented on the next cycle (back-to-back, no bubble).
  - Else: go to IDLE.
- enable deasserted mid-packet: current packet completes; no new packet starts until enable=1.
- DONE: done=1 and tvalid=0, held until reset.
- NUM_PKTS=0: run continuously; done stays 0; pkt_count wraps from 0xFFFFFFFF to 0 with no other effect.
- Single-beat packet (PKT_BYTES <= bytes-per-beat): tlast=1 on the first beat.

Test Plan:
- Reset timing (defaults): reset high 10 cycles, then low -> dut_reset falls exactly 200 edges later; first tvalid 16+1 cycles after that with enable=1.
- Packet format (defaults): with tready=1 -> each packet is 2 beats; tkeep=all ones on both beats; packet 0 byte k = k; packet 1 byte 0 = 0x01; tuser[23:16] cycles 0x01, 0x04, 0x10, 0x40, 0x01; tuser[15:0]=64.
- Partial last beat: PKT_BYTES=65, C_DATA_WIDTH=256 -> 3 beats; last beat tkeep=0x1, byte = (seq+64) mod 256.
- Backpressure: tready toggled randomly -> data stable during stalls, no beat lost or duplicated; pkt_count=64 and done=1 after 64 packets.
- IPG and enable: IPG_CYCLES=3 -> exactly 3 idle cycles between tlast and the next tvalid. enable dropped mid-packet -> packet completes, then tvalid stays 0 until enable=1.
- Reset mid-packet: reset asserted during beat 1 of packet 5 -> tvalid=0 and pkt_count=0 next edge, dut_reset=1; full sequence repeats with seq restarting at 0.
